// File: rtl/wash_cycle_controller.sv
// Washing-machine sequencer: coin arming, timed soak/wash/rinse/spin phases,
// lid-open pause, cancel drain, spin-imbalance retries and motor fault handling.
module wash_cycle_controller #(
   parameter int COINS_REQUIRED    = 2,
   parameter int COIN_W            = 3,
   parameter int TIMER_W           = 16,
   parameter int SOAK_CYCLES       = 8,
   parameter int WASH_CYCLES       = 12,
   parameter int RINSE_CYCLES      = 6,
   parameter int RINSE_PASSES      = 2,
   parameter int SPIN_CYCLES       = 10,
   parameter int IMBALANCE_RETRIES = 3
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               sig_Coin,
   input  logic               sig_Lid_Closed,
   input  logic               sig_Cancel,
   input  logic               sig_Out_Of_Balance,
   input  logic               sig_Motor_Failure,
   output logic [2:0]         state,
   output logic [TIMER_W-1:0] timer_remaining,
   output logic [3:0]         rinse_pass,
   output logic [COIN_W-1:0]  coins,
   output logic               paused,
   output logic               refund,
   output logic               done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READY = 3'd1,
      SOAK  = 3'd2,
      WASH  = 3'd3,
      RINSE = 3'd4,
      SPIN  = 3'd5,
      DONE  = 3'd6,
      FAULT = 3'd7
   } phase_t;

   localparam logic [TIMER_W-1:0] SOAK_LOAD   = TIMER_W'(SOAK_CYCLES - 1);
   localparam logic [TIMER_W-1:0] WASH_LOAD   = TIMER_W'(WASH_CYCLES - 1);
   localparam logic [TIMER_W-1:0] RINSE_LOAD  = TIMER_W'(RINSE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] SPIN_LOAD   = TIMER_W'(SPIN_CYCLES - 1);
   localparam logic [COIN_W-1:0]  COIN_TARGET = COIN_W'(COINS_REQUIRED);
   localparam logic [COIN_W-1:0]  COIN_MAX    = {COIN_W{1'b1}};
   localparam logic [3:0]         PASS_TARGET = 4'(RINSE_PASSES);
   localparam logic [3:0]         RETRY_LIMIT = 4'(IMBALANCE_RETRIES);

   phase_t              phase_q;
   logic                coin_prev;
   logic [3:0]          imb_cnt;
   logic                coin_rise;
   logic [COIN_W-1:0]   coins_inc;
   logic [3:0]          rinse_next;
   logic [3:0]          imb_next;

   assign state      = phase_q;
   assign coin_rise  = sig_Coin & ~coin_prev;
   assign coins_inc  = coins + 1'b1;
   assign rinse_next = rinse_pass + 4'd1;
   assign imb_next   = imb_cnt + 4'd1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase_q         <= IDLE;
         coin_prev       <= 1'b0;
         imb_cnt         <= 4'd0;
         timer_remaining <= '0;
         rinse_pass      <= 4'd0;
         coins           <= '0;
         paused          <= 1'b0;
         refund          <= 1'b0;
         done            <= 1'b0;
      end else begin
         coin_prev <= sig_Coin;
         refund    <= 1'b0;
         done      <= 1'b0;
         paused    <= 1'b0;
         case (phase_q)
            IDLE: begin
               if (sig_Cancel && coins != '0) begin
                  coins  <= '0;
                  refund <= 1'b1;
               end else if (coin_rise && coins != COIN_MAX) begin
                  coins <= coins_inc;
                  if (coins_inc >= COIN_TARGET) phase_q <= READY;
               end
            end
            READY: begin
               if (sig_Cancel) begin
                  phase_q <= IDLE;
                  coins   <= '0;
                  refund  <= 1'b1;
               end else if (sig_Lid_Closed) begin
                  phase_q         <= SOAK;
                  timer_remaining <= SOAK_LOAD;
               end
            end
            // Timed phases share one priority chain; only expiry is phase specific.
            SOAK, WASH, RINSE, SPIN: begin
               if (sig_Motor_Failure) begin
                  phase_q         <= FAULT;
                  timer_remaining <= '0;
               end else if (sig_Cancel && phase_q != SPIN) begin
                  phase_q         <= SPIN;
                  timer_remaining <= SPIN_LOAD;
               end else if (sig_Out_Of_Balance && phase_q == SPIN) begin
                  imb_cnt <= imb_next;
                  if (imb_next >= RETRY_LIMIT) begin
                     phase_q         <= FAULT;
                     timer_remaining <= '0;
                  end else begin
                     timer_remaining <= SPIN_LOAD;
                  end
               end else if (!sig_Lid_Closed) begin
                  paused <= 1'b1;
               end else if (timer_remaining != '0) begin
                  timer_remaining <= timer_remaining - 1'b1;
               end else begin
                  case (phase_q)
                     SOAK: begin
                        phase_q         <= WASH;
                        timer_remaining <= WASH_LOAD;
                     end
                     WASH: begin
                        phase_q         <= RINSE;
                        timer_remaining <= RINSE_LOAD;
                     end
                     RINSE: begin
                        rinse_pass <= rinse_next;
                        if (rinse_next < PASS_TARGET) begin
                           timer_remaining <= RINSE_LOAD;
                        end else begin
                           phase_q         <= SPIN;
                           timer_remaining <= SPIN_LOAD;
                        end
                     end
                     SPIN: begin
                        phase_q <= DONE;
                        done    <= 1'b1;
                     end
                     default: phase_q <= IDLE;
                  endcase
               end
            end
            DONE: begin
               phase_q    <= IDLE;
               coins      <= '0;
               rinse_pass <= 4'd0;
               imb_cnt    <= 4'd0;
            end
            // Fault exit needs the lid open so nobody restarts a faulted drum by accident.
            FAULT: begin
               if (sig_Cancel && !sig_Lid_Closed) begin
                  phase_q         <= IDLE;
                  coins           <= '0;
                  rinse_pass      <= 4'd0;
                  imb_cnt         <= 4'd0;
                  timer_remaining <= '0;
               end
            end
            default: phase_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Scoreboard bench for wash_cycle_controller: directed steps push expected
// outputs, a monitor pops and compares one entry after every rising edge.
module tb_wash_cycle_controller;

   logic        clock;
   logic        reset_n;
   logic        sig_Coin;
   logic        sig_Lid_Closed;
   logic        sig_Cancel;
   logic        sig_Out_Of_Balance;
   logic        sig_Motor_Failure;
   logic [2:0]  state;
   logic [15:0] timer_remaining;
   logic [3:0]  rinse_pass;
   logic [2:0]  coins;
   logic        paused;
   logic        refund;
   logic        done;

   typedef struct {
      logic [2:0]  st;
      logic [15:0] tmr;
      logic [3:0]  rp;
      logic [2:0]  cn;
      logic        p;
      logic        rf;
      logic        dn;
      string       nm;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   logic [2:0]  e_st;
   logic [15:0] e_tmr;
   logic [3:0]  e_rp;
   logic [2:0]  e_cn;
   logic        e_p;
   logic        e_rf;
   logic        e_dn;

   wash_cycle_controller dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .sig_Coin           (sig_Coin),
      .sig_Lid_Closed     (sig_Lid_Closed),
      .sig_Cancel         (sig_Cancel),
      .sig_Out_Of_Balance (sig_Out_Of_Balance),
      .sig_Motor_Failure  (sig_Motor_Failure),
      .state              (state),
      .timer_remaining    (timer_remaining),
      .rinse_pass         (rinse_pass),
      .coins              (coins),
      .paused             (paused),
      .refund             (refund),
      .done               (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_output(input exp_t e);
      total++;
      if ({state, timer_remaining, rinse_pass, coins, paused, refund, done} !==
          {e.st, e.tmr, e.rp, e.cn, e.p, e.rf, e.dn}) begin
         bad++;
         $display("[TB] FAIL %s: got st=%0d tmr=%0d rp=%0d cn=%0d p=%0b rf=%0b dn=%0b, want st=%0d tmr=%0d rp=%0d cn=%0d p=%0b rf=%0b dn=%0b",
                  e.nm, state, timer_remaining, rinse_pass, coins, paused, refund, done,
                  e.st, e.tmr, e.rp, e.cn, e.p, e.rf, e.dn);
      end
   endtask

   // Monitor: the outputs after each rising edge answer the oldest queued step.
   always @(posedge clock) begin
      #1;
      if (exp_q.size() > 0) check_output(exp_q.pop_front());
   end

   task automatic apply_stimulus(input logic coin, input logic lid, input logic cancel,
                                 input logic oob, input logic motor, input string nm);
      exp_t e;
      @(negedge clock);
      sig_Coin           = coin;
      sig_Lid_Closed     = lid;
      sig_Cancel         = cancel;
      sig_Out_Of_Balance = oob;
      sig_Motor_Failure  = motor;
      e.st = e_st; e.tmr = e_tmr; e.rp = e_rp; e.cn = e_cn;
      e.p  = e_p;  e.rf  = e_rf;  e.dn = e_dn; e.nm = nm;
      exp_q.push_back(e);
   endtask

   task automatic set_idle();
      e_st = 3'd0; e_tmr = 16'd0; e_rp = 4'd0; e_cn = 3'd0;
      e_p = 1'b0; e_rf = 1'b0; e_dn = 1'b0;
   endtask

   task automatic phase(input logic [2:0] st, input int dur, input string nm);
      for (int t = dur - 1; t >= 0; t--) begin
         e_st = st; e_tmr = 16'(t); e_p = 1'b0;
         apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, nm);
      end
   endtask

   task automatic arm_two_coins();
      e_cn = 3'd1;
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "coin1");
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "coin_gap");
      e_cn = 3'd2; e_st = 3'd1;
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "coin2_ready");
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, queue=%0d", exp_q.size());
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset_n = 1'b0;
      sig_Coin = 1'b0; sig_Lid_Closed = 1'b0; sig_Cancel = 1'b0;
      sig_Out_Of_Balance = 1'b0; sig_Motor_Failure = 1'b0;
      set_idle();
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "reset_state");
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "reset_holds");
      @(negedge clock);
      sig_Coin = 1'b0;
      reset_n = 1'b1;

      $display("[TB] full cycle");
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "idle");
      arm_two_coins();
      phase(3'd2, 8, "soak");
      phase(3'd3, 12, "wash");
      phase(3'd4, 6, "rinse_pass0");
      e_rp = 4'd1;
      phase(3'd4, 6, "rinse_pass1");
      e_rp = 4'd2;
      phase(3'd5, 10, "spin");
      e_st = 3'd6; e_tmr = 16'd0; e_dn = 1'b1;
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "done_pulse");
      set_idle();
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "back_to_idle");

      $display("[TB] held coin and refund");
      e_cn = 3'd1;
      for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "held_coin");
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "coin_release");
      e_cn = 3'd0; e_rf = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "refund_pulse");
      e_rf = 1'b0;
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "refund_ends");
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "cancel_no_coins");
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_after_cancel");

      $display("[TB] lid pause and single imbalance");
      arm_two_coins();
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ready_lid_open");
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ready_coin_ignored");
      phase(3'd2, 8, "soak2");
      e_st = 3'd3;
      for (int t = 11; t >= 7; t--) begin
         e_tmr = 16'(t);
         apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "wash_pre_pause");
      end
      e_p = 1'b1;
      for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "wash_paused");
      e_p = 1'b0;
      for (int t = 6; t >= 0; t--) begin
         e_tmr = 16'(t);
         apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "wash_resumed");
      end
      phase(3'd4, 6, "rinse2_pass0");
      e_rp = 4'd1;
      phase(3'd4, 6, "rinse2_pass1");
      e_rp = 4'd2; e_st = 3'd5;
      for (int t = 9; t >= 7; t--) begin
         e_tmr = 16'(t);
         apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "spin_pre_oob");
      end
      e_tmr = 16'd9;
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "spin_oob_reload");
      for (int t = 8; t >= 0; t--) begin
         e_tmr = 16'(t);
         apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "spin_after_oob");
      end
      e_st = 3'd6; e_dn = 1'b1;
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "done_after_oob");
      set_idle();
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "idle_after_oob");

      $display("[TB] cancel drain and imbalance fault");
      arm_two_coins();
      phase(3'd2, 8, "soak3");
      phase(3'd3, 12, "wash3");
      e_st = 3'd4;
      for (int t = 5; t >= 3; t--) begin
         e_tmr = 16'(t);
         apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rinse3");
      end
      e_st = 3'd5; e_tmr = 16'd9;
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "cancel_rinse_drain");
      e_tmr = 16'd8;
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "cancel_spin_ignored");
      e_tmr = 16'd9;
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "oob_retry1");
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "oob_retry2");
      e_st = 3'd7; e_tmr = 16'd0;
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "oob_fault");
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "fault_cancel_lid_closed");
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "fault_lid_open_only");
      set_idle();
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "fault_exit_no_refund");
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "idle_after_fault");

      $display("[TB] motor failure");
      arm_two_coins();
      e_st = 3'd2; e_tmr = 16'd7;
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "soak4_entry");
      e_tmr = 16'd6;
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "soak4");
      e_st = 3'd7; e_tmr = 16'd0;
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "motor_over_cancel");
      set_idle();
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "motor_fault_exit");
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "idle_after_motor");

      $display("[TB] async reset mid-spin");
      arm_two_coins();
      e_st = 3'd2; e_tmr = 16'd7;
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "soak5_entry");
      e_st = 3'd5; e_tmr = 16'd9;
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "cancel_soak_drain");
      e_tmr = 16'd8;
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "spin5");
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      sig_Coin = 1'b1;
      #1;
      total++;
      if ({state, timer_remaining, rinse_pass, coins, paused, refund, done} !== 29'd0) begin
         bad++;
         $display("[TB] FAIL async_reset: got st=%0d tmr=%0d cn=%0d rf=%0b, want all zero",
                  state, timer_remaining, coins, refund);
      end
      set_idle();
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "reset_held_coin");
      @(negedge clock);
      reset_n = 1'b1;
      e_cn = 3'd1;
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "coin_held_through_reset");
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "coin_counted_once");

      @(posedge clock);
      #3;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL queue_drain: got %0d pending, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wash_cycle_controller.md
# wash_cycle_controller

Parametrised second-generation washing-machine sequencer. It replaces the externally timed controller with internal phase timers, a multi-coin price, repeated rinse passes, lid-open pause and bounded spin-imbalance retries. It sits between the coin/lid/cancel front panel and the motor/valve drivers. It exposes a 3-bit phase code plus status flags.

## Interface
Parameters:
- COINS_REQUIRED, 2: coin pulses needed to arm a cycle (1..2^COIN_W-1).
- COIN_W, 3: coin counter width.
- TIMER_W, 16: phase timer width.
- SOAK_CYCLES, 8: soak duration in clocks (>=1).
- WASH_CYCLES, 12: wash duration in clocks (>=1).
- RINSE_CYCLES, 6: duration of one rinse pass (>=1).
- RINSE_PASSES, 2: number of rinse passes (1..15).
- SPIN_CYCLES, 10: spin duration in clocks (>=1).
- IMBALANCE_RETRIES, 3: spin restarts allowed before fault (1..15).

Ports:
- clock, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous active-low reset.
- sig_Coin, input, 1: coin sensor; level, one coin per rising edge.
- sig_Lid_Closed, input, 1: 1 = lid closed.
- sig_Cancel, input, 1: cancel request, level.
- sig_Out_Of_Balance, input, 1: drum imbalance during spin.
- sig_Motor_Failure, input, 1: motor fault.
- state, output, 3: 0 IDLE, 1 READY, 2 SOAK, 3 WASH, 4 RINSE, 5 SPIN, 6 DONE, 7 FAULT.
- timer_remaining, output, TIMER_W: clocks left in current timed phase; 0 otherwise.
- rinse_pass, output, 4: rinse passes completed.
- coins, output, COIN_W: coins accumulated.
- paused, output, 1: timed phase frozen by open lid.
- refund, output, 1: one-clock pulse when cancel discards inserted coins.
- done, output, 1: one-clock pulse in DONE.

## Operation
- Reset: state=IDLE. All outputs and internal counters are 0. The coin edge register is loaded with 0, so a coin held high during reset counts once after release.
- Input priority in timed phases (SOAK, WASH, RINSE, SPIN): sig_Motor_Failure > sig_Cancel > sig_Out_Of_Balance (SPIN only) > lid open > timer expiry.
- IDLE:
  - A rising edge on sig_Coin increments coins.
  - When coins reaches COINS_REQUIRED, next state is READY.
  - Cancel with coins>0 clears coins and pulses refund.
- READY:
  - sig_Lid_Closed=1 -> SOAK; timer loads SOAK_CYCLES-1.
  - Cancel -> IDLE, coins cleared, refund pulsed.
  - Further coins are ignored.
- Timed phases:
  - Lid open: paused=1 and the timer holds.
  - Otherwise the timer decrements each clock.
  - timer==0 with lid closed advances the phase on that edge.
- SOAK -> WASH (timer loads WASH_CYCLES-1). WASH -> RINSE (loads RINSE_CYCLES-1).
- RINSE: at expiry rinse_pass increments.
  - If the new value is < RINSE_PASSES, stay in RINSE and reload RINSE_CYCLES-1.
  - Else go to SPIN (loads SPIN_CYCLES-1).
- SPIN, sig_Out_Of_Balance=1:
  - Imbalance counter increments and the timer reloads SPIN_CYCLES-1.
  - If the counter reaches IMBALANCE_RETRIES, next state is FAULT.
- Cancel in SOAK/WASH/RINSE jumps to SPIN (drain), with the timer loaded. Cancel in SPIN is ignored.
- sig_Motor_Failure in any timed phase -> FAULT.
- SPIN expiry -> DONE. In DONE, done=1 for exactly one clock, then IDLE.
  - On entry to IDLE, coins, rinse_pass and the imbalance counter are cleared.
- FAULT is held until sig_Cancel=1 with sig_Lid_Closed=0, then IDLE. Coins are not refunded on fault exit.

## Timing
- All outputs are registered and change only on rising clock edges, except the asynchronous reset.
- An input sampled at edge N is reflected in state at edge N. Latency is one clock from input change to output.
- A timed phase with duration D occupies exactly D clocks when the lid stays closed. Each open-lid clock adds one clock.
- timer_remaining shows D-1 on the first clock of a phase and 0 on its last.
- Coin edge detection uses the previous-cycle sig_Coin register. A level held high counts once.
- The coin counter saturates; it never wraps.
- refund and done are single-clock pulses.
- Reset mid-cycle aborts immediately to IDLE with no refund pulse.

## Test plan
- Coin arming: COINS_REQUIRED=2, two separated coin pulses, lid closed -> state 0→1→2. SOAK lasts 8 clocks, WASH 12, two RINSE passes of 6, SPIN 10, done pulses once, then IDLE.
- Held coin: sig_Coin high for 5 clocks -> coins=1, state stays IDLE. Cancel -> coins=0 and refund=1 for one clock.
- Lid pause: open lid for 4 clocks mid-WASH -> paused=1, timer_remaining frozen. Total WASH occupancy is 16 clocks.
- Imbalance: assert sig_Out_Of_Balance once in SPIN -> timer reloads to 9, SPIN completes. Assert 3 times -> state=7.
- Cancel/fault: cancel in RINSE -> SPIN next clock. sig_Motor_Failure in SOAK -> FAULT. Cancel with lid closed -> FAULT held. Cancel with lid open -> IDLE.
- Async reset: assert reset_n low mid-SPIN between clock edges -> state=0 and all outputs 0 immediately.
